// File: rtl/din_debounce_pulse.sv
// din_debounce_pulse: synchronise, debounce and edge-qualify a raw asynchronous input line.
// Ports: clk, rst (async active-high); raw_in (async line); pulse_out (one cycle per accepted rise),
//        level_out (debounced level), glitch_cnt (saturating count of rejected transitions).
// Latency: raw rise to pulse_out/level_out = SYNC_STAGES + DEBOUNCE_CYCLES edges; no backpressure.
module din_debounce_pulse #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_in,
   output logic       pulse_out,
   output logic       level_out,
   output logic [7:0] glitch_cnt
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("din_debounce_pulse: SYNC_STAGES must be 2..4");
      end
      if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
         $error("din_debounce_pulse: DEBOUNCE_CYCLES must be 2..65535");
      end
   endgenerate

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      CHK_HIGH = 2'd1,
      HIGH     = 2'd2,
      CHK_LOW  = 2'd3
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;

   // Only the first synchroniser flop ever sees raw_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw_in};
      end
   end

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= LOW;
         cnt        <= '0;
         pulse_out  <= 1'b0;
         level_out  <= 1'b0;
         glitch_cnt <= 8'd0;
      end else begin
         // pulse_out is a strobe: it only survives the single cycle after qualification.
         pulse_out <= 1'b0;
         case (state)
            LOW: begin
               level_out <= 1'b0;
               if (s) begin
                  state <= CHK_HIGH;
                  cnt   <= CNT_ONE;
               end
            end
            CHK_HIGH: begin
               if (!s) begin
                  // Rejected rise; cnt is left alone and reloaded on the next CHK entry.
                  state <= LOW;
                  if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
               end else if (cnt == CNT_LAST) begin
                  state     <= HIGH;
                  level_out <= 1'b1;
                  pulse_out <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            HIGH: begin
               level_out <= 1'b1;
               if (!s) begin
                  state <= CHK_LOW;
                  cnt   <= CNT_ONE;
               end
            end
            CHK_LOW: begin
               if (s) begin
                  // Rejected fall: back to HIGH without a new pulse.
                  state <= HIGH;
                  if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
               end else if (cnt == CNT_LAST) begin
                  state     <= LOW;
                  level_out <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state     <= LOW;
               level_out <= 1'b0;
               pulse_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_din_debounce_pulse.sv
// tb_din_debounce_pulse: directed bench for din_debounce_pulse at default parameters.
// Drives raw_in between clock edges and samples outputs 1 ns after each rising edge.
// Includes a small 3-state counting model fed by pulse_out to stand in for the downstream FSM.
module tb_din_debounce_pulse;

   logic       clk = 1'b0;
   logic       rst;
   logic       raw_in;
   logic       pulse_out;
   logic       level_out;
   logic [7:0] glitch_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int pulse_cnt = 0;
   int base;

   // Downstream 3-state counter: dout high in its third state, wraps on the third din.
   logic [1:0] ds_state;
   logic       ds_dout;

   din_debounce_pulse dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in),
      .pulse_out  (pulse_out),
      .level_out  (level_out),
      .glitch_cnt (glitch_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) ds_state <= 2'd0;
      else if (pulse_out) ds_state <= (ds_state == 2'd2) ? 2'd0 : ds_state + 2'd1;
   end
   assign ds_dout = (ds_state == 2'd2);

   always @(negedge clk) begin
      if (pulse_out === 1'b1) pulse_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst    = 1'b1;
      raw_in = 1'b0;
      tick(3);
      check("rst_pulse", {31'd0, pulse_out}, 32'd0);
      check("rst_level", {31'd0, level_out}, 32'd0);
      check("rst_glitch", {24'd0, glitch_cnt}, 32'd0);

      // Clean rise held from edge 1: pulse exactly after edge 6, level from edge 6 on.
      rst    = 1'b0;
      raw_in = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick(1);
         check($sformatf("rise_pulse_e%0d", e), {31'd0, pulse_out}, (e == 6) ? 32'd1 : 32'd0);
         check($sformatf("rise_level_e%0d", e), {31'd0, level_out}, (e >= 6) ? 32'd1 : 32'd0);
      end
      check("rise_glitch", {24'd0, glitch_cnt}, 32'd0);

      // Clean fall: level drops after edge 6, no pulse on the falling path.
      base   = pulse_cnt;
      raw_in = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick(1);
         check($sformatf("fall_level_e%0d", e), {31'd0, level_out}, (e >= 6) ? 32'd0 : 32'd1);
      end
      tick(3);
      check("fall_no_pulse", pulse_cnt - base, 32'd0);

      // Three-cycle high from LOW is one sample short: rejected.
      base   = pulse_cnt;
      raw_in = 1'b1;
      tick(3);
      raw_in = 1'b0;
      tick(10);
      check("short_hi_pulses", pulse_cnt - base, 32'd0);
      check("short_hi_level", {31'd0, level_out}, 32'd0);
      check("short_hi_glitch", {24'd0, glitch_cnt}, 32'd1);

      // Go HIGH, then a two-cycle low dip: level holds, one more glitch, no pulse.
      raw_in = 1'b1;
      tick(10);
      check("hi_level", {31'd0, level_out}, 32'd1);
      base   = pulse_cnt;
      raw_in = 1'b0;
      tick(2);
      raw_in = 1'b1;
      tick(10);
      check("dip_level", {31'd0, level_out}, 32'd1);
      check("dip_pulses", pulse_cnt - base, 32'd0);
      check("dip_glitch", {24'd0, glitch_cnt}, 32'd2);

      // Return to LOW, then rise and reset asynchronously while CHK_HIGH holds cnt=2.
      raw_in = 1'b0;
      tick(10);
      raw_in = 1'b1;
      tick(4);
      #2;
      rst = 1'b1;
      #1;
      check("arst_pulse", {31'd0, pulse_out}, 32'd0);
      check("arst_level", {31'd0, level_out}, 32'd0);
      check("arst_glitch", {24'd0, glitch_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick(1);
         check($sformatf("arst_rise_pulse_e%0d", e), {31'd0, pulse_out}, (e == 6) ? 32'd1 : 32'd0);
      end

      // Three clean presses into the downstream counter from a fresh reset.
      raw_in = 1'b0;
      tick(10);
      rst = 1'b1;
      tick(1);
      rst  = 1'b0;
      base = pulse_cnt;
      for (int p = 1; p <= 3; p++) begin
         raw_in = 1'b1;
         tick(10);
         raw_in = 1'b0;
         tick(10);
         check($sformatf("press%0d_dout", p), {31'd0, ds_dout}, (p == 2) ? 32'd1 : 32'd0);
      end
      check("press_pulses", pulse_cnt - base, 32'd3);
      check("press_glitch", {24'd0, glitch_cnt}, 32'd0);

      // 300 rejected two-cycle highs: counter reaches 255 and saturates, never a pulse.
      base = pulse_cnt;
      for (int i = 1; i <= 300; i++) begin
         raw_in = 1'b1;
         tick(2);
         raw_in = 1'b0;
         tick(3);
         if (i == 254) check("sat_254", {24'd0, glitch_cnt}, 32'd254);
         if (i == 255) check("sat_255", {24'd0, glitch_cnt}, 32'd255);
      end
      check("sat_300", {24'd0, glitch_cnt}, 32'd255);
      check("sat_pulses", pulse_cnt - base, 32'd0);
      check("sat_level", {31'd0, level_out}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/din_debounce_pulse.md
Name: din_debounce_pulse

Overview:
- Input conditioner for the 3-state din-counting FSM; sits directly upstream of it and drives that FSM's din.
- Synchronises an asynchronous raw input (button/external line), debounces it, and emits exactly one single-cycle pulse per qualified rising edge, so the downstream FSM advances once per real press.
- Also exports the debounced level and a saturating glitch counter for coverage and debug.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a level change; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the internal stability counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- raw_in  input  1  asynchronous raw input line.
- pulse_out  output  1  one-cycle pulse on each accepted rising edge; connects to the downstream FSM's din.
- level_out  output  1  debounced level.
- glitch_cnt  output  8  count of rejected transitions; saturates at 255.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high, on ports clk and rst.
  - While rst=1: sync chain=0, state=LOW, cnt=0, pulse_out=0, level_out=0, glitch_cnt=0.
  - An assertion mid-operation aborts any check in progress immediately.
- Synchroniser: SYNC_STAGES flops in series; s denotes the last stage. No other logic reads raw_in.
- FSM states: LOW, CHK_HIGH, HIGH, CHK_LOW. All outputs are registered.
  - LOW: level_out=0. If s=1: go to CHK_HIGH, cnt<=1.
  - CHK_HIGH: level_out=0.
    - If s=0: go to LOW and count a glitch.
    - Else if cnt==DEBOUNCE_CYCLES-1: go to HIGH, level_out<=1, pulse_out<=1.
    - Else cnt<=cnt+1.
  - HIGH: level_out=1. If s=0: go to CHK_LOW, cnt<=1.
  - CHK_LOW: level_out=1.
    - If s=1: go to HIGH and count a glitch.
    - Else if cnt==DEBOUNCE_CYCLES-1: go to LOW, level_out<=0.
    - Else cnt<=cnt+1.
- pulse_out:
  - High for exactly one cycle, only on the CHK_HIGH->HIGH transition.
  - Never asserted on a falling edge.
  - Never asserted twice without an intervening LOW.
- Latency: counting the first posedge that samples raw_in=1 as edge 1:
  - pulse_out and level_out rise after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 at defaults).
  - The falling path is symmetric for level_out.
- Glitch: a level change that reverts before qualification is rejected.
  - glitch_cnt<=glitch_cnt+1 if below 255, otherwise it holds at 255 (no wrap).
  - cnt is not reset by the rejection itself; it is reloaded on the next entry into a CHK state.
- raw_in held high through reset release: treated as a new rising edge. It debounces normally and produces one pulse.
- cnt never exceeds DEBOUNCE_CYCLES-1. Encodings outside the 4 states return to LOW, with outputs 0.

Test Plan:
- Reset, then raw_in=1 held from edge 1 (defaults) -> pulse_out=1 only in the cycle after edge 6; level_out=1 from then on; glitch_cnt=0.
- From LOW, raw_in=1 for 3 cycles then 0 -> no pulse; level_out stays 0; glitch_cnt=1.
- From HIGH, raw_in low for 2 cycles then high again -> level_out stays 1; no pulse; glitch_cnt increments by 1.
- 3 clean presses (high 10 cycles, low 10 cycles each) driving the downstream FSM -> exactly 3 pulses; the downstream FSM's dout is 1 after press 2 and 0 after press 3.
- rst asserted asynchronously between clock edges while in CHK_HIGH with cnt=2 -> all outputs 0 immediately; after release with raw_in still 1, one pulse appears after SYNC_STAGES+DEBOUNCE_CYCLES edges.
- 300 forced glitches -> glitch_cnt reads 255 and holds; there are no pulses.
